snake_dir_ctrl: RTL

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_pkg.sv | 42 ++++
 rtl/snake_dir_ctrl_if.sv | 20 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/snake_dir_ctrl.sv | 80 ++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Direction encodings and steering rules shared by the direction controller
// and the snake movement logic.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam int unsigned NUM_BTNS  = 4;
    localparam dir_e        DIR_RESET = DIR_RIGHT;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } dir_req_t;

    // Opposite directions are bitwise inverses of each other.
    function automatic dir_e reverse_of(input dir_e d);
        return dir_e'(~d);
    endfunction

    function automatic logic is_reversal(input dir_e cur, input dir_e req);
        return req == reverse_of(cur);
    endfunction

    // Button index equals its direction code; the lowest set bit wins.
    function automatic dir_req_t pick_press(input logic [NUM_BTNS-1:0] press);
        dir_req_t r;
        r = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (press[i]) begin
                r.valid = 1'b1;
                r.dir   = dir_e'(2'(i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Button / step-tick inputs and committed-direction outputs of the snake
// direction controller.
interface snake_dir_ctrl_if;
    logic [3:0] btn;
    logic       move_tick;
    logic [1:0] dir;
    logic       dir_chg;
    logic       pend_valid;
    logic [3:0] btn_db;

    modport master (
        output btn, move_tick,
        input  dir, dir_chg, pend_valid, btn_db
    );

    modport slave (
        input  btn, move_tick,
        output dir, dir_chg, pend_valid, btn_db
    );
endinterface

// File: rtl/btn_debounce.sv
// One button bit: 2-flop synchronizer followed by a level debouncer that
// accepts a new level only after DB_CYCLES consecutive differing cycles.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic clear_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int unsigned     CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sync_d = {sync_q[0], btn_raw};
        cnt_d  = '0;
        db_d   = db_q;
        // Counter only advances while the synced level disagrees; any agreeing
        // cycle falls through to the zero default and restarts the count.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake steering: debounced direction buttons become a single pending request
// that is committed to the registered direction on each move_tick.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 250000
) (
    input logic             clk,
    input logic             clear_n,
    snake_dir_ctrl_if.slave bus
);

    logic [NUM_BTNS-1:0] btn_db;
    logic [NUM_BTNS-1:0] btn_db_prev_q, btn_db_prev_d;
    logic [NUM_BTNS-1:0] press;
    dir_req_t            req;
    logic                accept;

    dir_e dir_q, dir_d;
    dir_e pend_dir_q, pend_dir_d;
    logic pend_valid_q, pend_valid_d;
    logic dir_chg_q, dir_chg_d;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .clear_n(clear_n),
            .btn_raw(bus.btn[g]),
            .btn_db (btn_db[g])
        );
    end

    assign press  = btn_db & ~btn_db_prev_q;
    assign req    = pick_press(press);
    // Reversal is judged against the committed direction, never the pending one.
    assign accept = req.valid && !is_reversal(dir_q, req.dir);

    always_comb begin
        btn_db_prev_d = btn_db;
        dir_d         = dir_q;
        pend_dir_d    = pend_dir_q;
        pend_valid_d  = pend_valid_q;
        if (bus.move_tick) begin
            if (accept) begin
                dir_d = req.dir;
            end else if (pend_valid_q) begin
                dir_d = pend_dir_q;
            end
            pend_valid_d = 1'b0;
        end else if (accept) begin
            pend_dir_d   = req.dir;
            pend_valid_d = 1'b1;
        end
        dir_chg_d = (dir_d != dir_q);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            btn_db_prev_q <= '0;
            dir_q         <= DIR_RESET;
            pend_dir_q    <= DIR_RESET;
            pend_valid_q  <= 1'b0;
            dir_chg_q     <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db_prev_d;
            dir_q         <= dir_d;
            pend_dir_q    <= pend_dir_d;
            pend_valid_q  <= pend_valid_d;
            dir_chg_q     <= dir_chg_d;
        end
    end

    assign bus.dir        = dir_q;
    assign bus.dir_chg    = dir_chg_q;
    assign bus.pend_valid = pend_valid_q;
    assign bus.btn_db     = btn_db;

endmodule
